red_pitaya_sort_pulser: RTL

- Downstream stage of the FADS sorter: consumes its sort trigger and generates the bipolar square-wave burst driven to the fast DAC, which feeds the external HV amplifier that deflects droplets.
- Sits between the FADS block's sort_trig output and the DAC output mux.
- Burst shape is set by static configuration ports driven from the FADS register bank.

---
 rtl/red_pitaya_sort_pulser.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/red_pitaya_sort_pulser.sv
// Sort pulser: turns a FADS sort trigger into a bipolar square-wave burst for the HV DAC.
// Optional statistics counters are built when SORT_PULSER_STATS_EN is defined.
module red_pitaya_sort_pulser #(
  parameter int DW = 14,
  parameter int PW = 16,
  parameter int CW = 32
) (
  input  logic          adc_clk_i,
  input  logic          adc_rst_i,
  input  logic          sort_trig_i,
  input  logic          enable_i,
  input  logic [PW-1:0] half_period_i,
  input  logic [PW-1:0] num_cycles_i,
  input  logic [DW-2:0] amplitude_i,
  input  logic [PW-1:0] holdoff_i,
  output logic [DW-1:0] dac_o,
  output logic          hv_gate_o,
  output logic          busy_o,
  output logic [CW-1:0] fired_cnt_o,
  output logic [CW-1:0] missed_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_POS, S_NEG, S_HOLD} state_t;

  state_t                state_q, state_d;
  logic                  trig_q, armed_q;
  logic [PW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         ncyc_q, ncyc_d;
  logic [PW-1:0]         hp_q, hp_d;
  logic [PW-1:0]         hold_q, hold_d;
  logic [DW-2:0]         amp_q, amp_d;
  logic signed [DW-1:0]  dac_q, dac_d;
  logic                  gate_q, gate_d;
  logic                  rise;
  logic [PW-1:0]         hp_eff;

  function automatic logic signed [DW-1:0] pos_sample(input logic [DW-2:0] a);
    return $signed({1'b0, a});
  endfunction

  function automatic logic signed [DW-1:0] neg_sample(input logic [DW-2:0] a);
    return -$signed({1'b0, a});
  endfunction

  // armed_q masks the first edge after reset so a trigger already high cannot fire
  assign rise   = sort_trig_i && !trig_q && armed_q;
  assign hp_eff = (half_period_i == '0) ? PW'(1) : half_period_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ncyc_d  = ncyc_q;
    hp_d    = hp_q;
    hold_d  = hold_q;
    amp_d   = amp_q;
    dac_d   = dac_q;
    gate_d  = gate_q;
    case (state_q)
      S_IDLE: begin
        dac_d  = '0;
        gate_d = 1'b0;
        if (rise && enable_i && (num_cycles_i != '0)) begin
          hp_d    = hp_eff;
          hold_d  = holdoff_i;
          amp_d   = amplitude_i;
          ncyc_d  = num_cycles_i;
          cnt_d   = hp_eff - PW'(1);
          dac_d   = pos_sample(amplitude_i);
          gate_d  = 1'b1;
          state_d = S_POS;
        end
      end
      S_POS: begin
        if (cnt_q == '0) begin
          cnt_d   = hp_q - PW'(1);
          dac_d   = neg_sample(amp_q);
          state_d = S_NEG;
        end else begin
          cnt_d = cnt_q - PW'(1);
        end
      end
      S_NEG: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - PW'(1);
        end else if (ncyc_q != PW'(1)) begin
          ncyc_d  = ncyc_q - PW'(1);
          cnt_d   = hp_q - PW'(1);
          dac_d   = pos_sample(amp_q);
          state_d = S_POS;
        end else begin
          dac_d  = '0;
          gate_d = 1'b0;
          if (hold_q == '0) begin
            state_d = S_IDLE;
          end else begin
            cnt_d   = hold_q - PW'(1);
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - PW'(1);
      end
      default: state_d = S_IDLE;
    endcase
    // enable low overrides any active phase and skips holdoff
    if (!enable_i && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      dac_d   = '0;
      gate_d  = 1'b0;
    end
  end

  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      state_q <= S_IDLE;
      trig_q  <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      ncyc_q  <= '0;
      hp_q    <= '0;
      hold_q  <= '0;
      amp_q   <= '0;
      dac_q   <= '0;
      gate_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q  <= sort_trig_i;
      armed_q <= 1'b1;
      cnt_q   <= cnt_d;
      ncyc_q  <= ncyc_d;
      hp_q    <= hp_d;
      hold_q  <= hold_d;
      amp_q   <= amp_d;
      dac_q   <= dac_d;
      gate_q  <= gate_d;
    end
  end

  assign dac_o     = dac_q;
  assign hv_gate_o = gate_q;
  assign busy_o    = (state_q != S_IDLE);

`ifdef SORT_PULSER_STATS_EN
  logic [CW-1:0] fired_q, fired_d, missed_q, missed_d;
  logic          accept, drop;

  assign accept = rise && (state_q == S_IDLE) && enable_i && (num_cycles_i != '0);
  assign drop   = rise && (state_q != S_IDLE);

  always_comb begin
    fired_d  = fired_q + CW'(accept);
    missed_d = missed_q + CW'(drop);
  end

  always_ff @(posedge adc_clk_i or posedge adc_rst_i) begin
    if (adc_rst_i) begin
      fired_q  <= '0;
      missed_q <= '0;
    end else begin
      fired_q  <= fired_d;
      missed_q <= missed_d;
    end
  end

  assign fired_cnt_o  = fired_q;
  assign missed_cnt_o = missed_q;
`else
  assign fired_cnt_o  = '0;
  assign missed_cnt_o = '0;
`endif

endmodule
